// File: rtl/rf_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter_if
// Bundles the two writeback request channels, the registered register-file
// write port and the pending-write mask of rf_wr_arbiter.
//
// Signals (named from the arbiter's point of view):
//   i_a_valid/o_a_ready/i_a_addr/i_a_data : requester A (ALU writeback)
//   i_b_valid/o_b_ready/i_b_addr/i_b_data : requester B (load/multiply)
//   o_we/o_waddr/o_wdata                  : register file write port
//   o_busy_mask                           : bit r set = write to r pending
//
// Modports:
//   master : requesters + register file side (drives the i_* signals)
//   slave  : the arbiter itself (drives the o_* signals)
// -----------------------------------------------------------------------------
interface rf_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic              i_a_valid;
  logic              o_a_ready;
  logic [AW-1:0]     i_a_addr;
  logic [DW-1:0]     i_a_data;

  logic              i_b_valid;
  logic              o_b_ready;
  logic [AW-1:0]     i_b_addr;
  logic [DW-1:0]     i_b_data;

  logic              o_we;
  logic [AW-1:0]     o_waddr;
  logic [DW-1:0]     o_wdata;
  logic [2**AW-1:0]  o_busy_mask;

  modport master (
    output i_a_valid, i_a_addr, i_a_data,
    output i_b_valid, i_b_addr, i_b_data,
    input  o_a_ready, o_b_ready,
    input  o_we, o_waddr, o_wdata, o_busy_mask
  );

  modport slave (
    input  i_a_valid, i_a_addr, i_a_data,
    input  i_b_valid, i_b_addr, i_b_data,
    output o_a_ready, o_b_ready,
    output o_we, o_waddr, o_wdata, o_busy_mask
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
// Shares the register file's single write port between two writeback
// requesters. Each requester feeds its own DEPTH-entry queue; an arbiter
// drains one queue head per cycle into a registered write port. A pending-
// write mask covers every queued entry plus the entry held in the write
// port, so issue logic can stall RAW hazards until the data is committed.
//
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous, active-high reset
//   bus   : rf_wr_arbiter_if.slave (request channels, write port, busy mask)
//
// Parameters: DEPTH (entries per queue, power of 2, >=2), AW, DW.
//
// Build option: define WRARB_FIXED_PRIO_EN for fixed priority (A always wins
// a tie, no round-robin state). Undefined: round-robin, A wins the first tie.
// -----------------------------------------------------------------------------
module rf_wr_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic            i_clk,
  input logic            i_rst,
  rf_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(DEPTH);  // slot index width
  localparam int PW = IW + 1;         // pointer width, wraps modulo 2*DEPTH

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  // Queue 0 = requester A, queue 1 = requester B.
  entry_t               r_mem [2][DEPTH];
  logic [1:0][PW-1:0]   r_wr;
  logic [1:0][PW-1:0]   r_rd;
  logic [1:0][PW-1:0]   w_cnt;
  logic [1:0]           w_full;
  logic [1:0]           w_empty;
  logic [1:0]           w_push;
  logic [1:0]           w_pop;
  entry_t               w_in   [2];
  entry_t               w_head [2];
  logic [1:0][DEPTH-1:0] w_slot_vld;

  logic                 w_grant_a;
  logic                 w_grant_b;
  logic                 w_grant;

  logic                 r_we;
  logic [AW-1:0]        r_waddr;
  logic [DW-1:0]        r_wdata;
  logic [2**AW-1:0]     w_busy;

  assign w_in[0] = '{addr: bus.i_a_addr, data: bus.i_a_data};
  assign w_in[1] = '{addr: bus.i_b_addr, data: bus.i_b_data};

  for (genvar q = 0; q < 2; q++) begin : g_queue
    assign w_cnt[q]   = r_wr[q] - r_rd[q];
    assign w_empty[q] = (r_wr[q] == r_rd[q]);
    // Full: same slot index, opposite lap.
    assign w_full[q]  = (r_wr[q][IW] != r_rd[q][IW]) &&
                        (r_wr[q][IW-1:0] == r_rd[q][IW-1:0]);
    assign w_head[q]  = r_mem[q][r_rd[q][IW-1:0]];

    // A slot is live when its distance from the read pointer is below the
    // occupancy count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [IW-1:0] w_off;
      assign w_off            = IW'(i) - r_rd[q][IW-1:0];
      assign w_slot_vld[q][i] = ({1'b0, w_off} < w_cnt[q]);
    end
  end

  // Ready depends only on queue state, so a full queue never sees a
  // same-cycle push and pop.
  assign bus.o_a_ready = !w_full[0];
  assign bus.o_b_ready = !w_full[1];

  // Writes to register 0 complete the handshake but are never stored.
  assign w_push[0] = bus.i_a_valid && !w_full[0] && (bus.i_a_addr != '0);
  assign w_push[1] = bus.i_b_valid && !w_full[1] && (bus.i_b_addr != '0);

`ifdef WRARB_FIXED_PRIO_EN
  assign w_grant_a = !w_empty[0];
`else
  logic r_last_b;  // 1 = B was granted most recently

  assign w_grant_a = !w_empty[0] && (w_empty[1] || r_last_b);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_b <= 1'b1;
    end else if (w_grant_a) begin
      r_last_b <= 1'b0;
    end else if (w_grant_b) begin
      r_last_b <= 1'b1;
    end
  end
`endif

  assign w_grant_b = !w_empty[1] && !w_grant_a;
  assign w_grant   = w_grant_a || w_grant_b;
  assign w_pop     = {w_grant_b, w_grant_a};

  // NOTE: queue storage carries no reset; the pointers alone define which
  // slots are live, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    for (int q = 0; q < 2; q++) begin
      if (w_push[q]) begin
        r_mem[q][r_wr[q][IW-1:0]] <= w_in[q];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (w_push[q]) r_wr[q] <= r_wr[q] + PW'(1);
        if (w_pop[q])  r_rd[q] <= r_rd[q] + PW'(1);
      end
    end
  end

  // Registered write port: one-cycle o_we pulse per popped entry. Address
  // and data hold their last value while idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant;
      if (w_grant) begin
        r_waddr <= w_grant_a ? w_head[0].addr : w_head[1].addr;
        r_wdata <= w_grant_a ? w_head[0].data : w_head[1].data;
      end
    end
  end

  // NOTE: the mask is fully defaulted before the loops so no latch is
  // inferred for bits that no entry touches.
  always_comb begin
    w_busy = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_slot_vld[q][i]) w_busy[r_mem[q][i].addr] = 1'b1;
      end
    end
    if (r_we) w_busy[r_waddr] = 1'b1;
  end

  assign bus.o_we        = r_we;
  assign bus.o_waddr     = r_waddr;
  assign bus.o_wdata     = r_wdata;
  assign bus.o_busy_mask = w_busy;

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A (ALU writeback) and B (load/multiply unit). Each requester has its own small queue. A round-robin arbiter drains the queues into a registered write port that drives the register file's i_we/i_waddr/i_wdata. A per-register pending-write mask is exported so the issue logic can stall read-after-write hazards until the register file actually holds the data.

Parameters:
DEPTH, 2, entries per requester queue (power of 2, >=2)
AW, 5, register address width
DW, 32, register data width

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_a_valid  input  1  requester A write request
o_a_ready  output  1  A queue can accept
i_a_addr  input  AW  A destination register
i_a_data  input  DW  A write data
i_b_valid  input  1  requester B write request
o_b_ready  output  1  B queue can accept
i_b_addr  input  AW  B destination register
i_b_data  input  DW  B write data
o_we  output  1  register file write enable (registered)
o_waddr  output  AW  register file write address (registered)
o_wdata  output  DW  register file write data (registered)
o_busy_mask  output  2**AW  bit r set = write to r pending, not yet in register file

Behaviour:
- Reset (asynchronous):
  - queues emptied; o_we=0, o_waddr=0, o_wdata=0.
  - round-robin pointer = "B last granted", so A wins the first tie.
  - o_busy_mask=0; o_a_ready=o_b_ready=1.
  - Reset mid-operation drops all pending writes; no write port pulse after reset release until a new request.
- Handshake:
  - Transfer on edge where valid && ready.
  - ready = !full of that queue, combinational from queue state only (no dependence on valid).
  - Push and pop in the same cycle on a full queue is not allowed: ready stays 0 while full.
- Address 0: handshake completes normally, but the entry is discarded (not queued, no o_we, mask bit 0 never set).
- Arbitration, evaluated each cycle on queue heads:
  - Only one queue non-empty: grant that queue.
  - Both queues non-empty: grant the queue not granted last; pointer updates on every grant.
  - Neither queue non-empty: no grant; o_we=0 next cycle.
- Grant pops the head at the edge and loads o_we=1 with o_waddr/o_wdata from that entry. o_we is a one-cycle pulse per entry; back-to-back grants give consecutive o_we cycles.
- Latency: entry accepted at edge N is popped at edge N+1 at the earliest, so o_we is high during cycle N+1..N+2. The register file commits at edge N+2.
- Throughput: one write per cycle total across both requesters.
- o_busy_mask, combinational: bit r = OR over every valid entry in both queues and the output stage (o_we && o_waddr==r). The bit clears once the output stage no longer holds r.
- Ordering:
  - FIFO order is guaranteed within a requester.
  - No ordering is guaranteed between A and B for the same address. Issue logic uses o_busy_mask to avoid this case.
- Queue pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full = MSBs differ and low bits are equal.

Optional Feature:
WRARB_FIXED_PRIO_EN:
- Defined: fixed priority; A always wins when both queues are non-empty, and the round-robin pointer is removed.
- Undefined: round-robin as specified above.

Test Plan:
- Assert i_rst mid-run -> o_we=0, o_busy_mask=0, both readies=1 immediately, without waiting for a clock edge.
- Single A write: addr 5, data 0xDEADBEEF, accepted at edge N -> o_we=1, o_waddr=5, o_wdata=0xDEADBEEF in cycle N+1 only. o_busy_mask[5]=1 from after edge N until edge N+2.
- A (3, 0x11) and B (4, 0x22) accepted on the same edge after reset -> o_we for addr 3 then addr 4 on consecutive cycles; with WRARB_FIXED_PRIO_EN the order is the same.
- A write to addr 0 with data 0xFFFFFFFF -> handshake completes, o_we stays 0, o_busy_mask stays 0.
- Both valid held 8 cycles, DEPTH=2 -> grants alternate A,B,A,B. Each ready drops to 0 when its queue holds 2 entries and rises once a pop frees a slot. Every accepted entry is written exactly once, in per-requester order.
- Three A entries queued, then i_rst pulsed -> no o_we ever issued for them; after release, a new B write (7, 0x77) -> o_we at the expected N+1 cycle.
